// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg -- shared CPU definitions used by the instruction-fetch unit.
//   state_e   : ifetch sequencer states
//   int_src_e : interrupt-source code reported alongside an injected BRK
//   VEC_*     : hardware vector addresses (reset, NMI, IRQ)
//   OP_BRK    : opcode injected in place of a fetched opcode on interrupt
// -----------------------------------------------------------------------------
package ifetch_pkg;

   typedef enum logic [2:0] {
      RST_LO  = 3'd0,
      RST_HI  = 3'd1,
      RST_VEC = 3'd2,
      FETCH   = 3'd3,
      LATCH   = 3'd4,
      EXEC    = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      INT_NONE = 2'b00,
      INT_IRQ  = 2'b01,
      INT_NMI  = 2'b10
   } int_src_e;

   localparam logic [15:0] VEC_NMI = 16'hFFFA;
   localparam logic [15:0] VEC_RST = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ = 16'hFFFE;
   localparam logic [7:0]  OP_BRK  = 8'h00;

endpackage

// File: rtl/ifetch_if.sv
// -----------------------------------------------------------------------------
// ifetch_if -- memory bus between the fetch unit and memory.
//   addr   : 16-bit read address (fetch unit drives)
//   rd_en  : read strobe for addr (fetch unit drives)
//   sync   : marks an opcode-fetch address cycle (fetch unit drives)
//   data_i : read data, valid the cycle after addr/rd_en (memory drives)
//   rdy    : bus ready; low stalls the fetch unit (memory drives)
// -----------------------------------------------------------------------------
interface ifetch_if;
   logic [15:0] addr;
   logic        rd_en;
   logic        sync;
   logic [7:0]  data_i;
   logic        rdy;

   modport master (output addr, rd_en, sync, input data_i, rdy);
   modport slave  (input addr, rd_en, sync, output data_i, rdy);
endinterface

// File: rtl/ifetch_nmi_edge.sv
// -----------------------------------------------------------------------------
// nmi_edge -- registered falling-edge detector for nmi_n with a pending latch.
//   i_clk, i_rst : clock, synchronous active-high reset
//   nmi_n_i      : raw NMI line (active low)
//   clr_i        : clears the pending flag (NMI has been injected)
//   pend_o       : NMI pending
// Only instantiated when IFETCH_IRQ_EN is defined.
// -----------------------------------------------------------------------------
module nmi_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic nmi_n_i,
   input  logic clr_i,
   output logic pend_o
);
   logic nmi_n_q;
   logic pend_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         nmi_n_q <= 1'b1;
         pend_q  <= 1'b0;
      end else begin
         nmi_n_q <= nmi_n_i;
         // A fresh edge wins over a same-cycle clear so it is never lost.
         if (nmi_n_q && !nmi_n_i) begin
            pend_q <= 1'b1;
         end else if (clr_i) begin
            pend_q <= 1'b0;
         end
      end
   end

   assign pend_o = pend_q;
endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch -- instruction-fetch unit: loads pc from the reset vector, then
// repeatedly fetches an opcode (FETCH), latches it (LATCH) and waits in EXEC
// while the executor consumes operands and redirects pc.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   bus            : ifetch_if master (addr, rd_en, sync out; data_i, rdy in)
//   opcode         : instruction register
//   ir_valid       : one-cycle pulse while the opcode is being latched
//   pc             : program counter
//   pc_inc         : executor consumed an operand byte (pc += 1), EXEC only
//   pc_load, pc_in : executor loads pc (wins over pc_inc), EXEC only
//   insn_done      : executor finished, next cycle is FETCH
//   irq_n, nmi_n, i_flag : interrupt lines and P[I]
//   int_src        : 00 none, 01 IRQ, 10 NMI; qualifies an injected BRK
// Build option: define IFETCH_IRQ_EN to enable BRK injection on NMI/IRQ;
// otherwise the interrupt inputs are ignored and int_src stays 00.
// -----------------------------------------------------------------------------
module ifetch
   import ifetch_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   ifetch_if.master         bus,
   output logic [7:0]       opcode,
   output logic             ir_valid,
   output logic [15:0]      pc,
   input  logic             pc_inc,
   input  logic             pc_load,
   input  logic [15:0]      pc_in,
   input  logic             insn_done,
   input  logic             irq_n,
   input  logic             nmi_n,
   input  logic             i_flag,
   output logic [1:0]       int_src
);
   localparam logic [15:0] VEC_RST_HI = VEC_RST + 16'd1;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  opcode_q, opcode_d;
   int_src_e    int_src_q, int_src_d;
   logic [15:0] bus_addr;
   logic        bus_rd_en;
   logic        bus_sync;
   logic        inj_nmi;
   logic        inj_irq;

`ifdef IFETCH_IRQ_EN
   logic nmi_pend;
   logic nmi_clr;

   // Pending NMI is consumed only when the LATCH cycle actually completes.
   assign nmi_clr = (state_q == LATCH) && bus.rdy && nmi_pend;

   nmi_edge u_nmi_edge (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .nmi_n_i (nmi_n),
      .clr_i   (nmi_clr),
      .pend_o  (nmi_pend)
   );

   assign inj_nmi = nmi_pend;
   assign inj_irq = !irq_n && !i_flag;
`else
   logic unused_int;
   assign unused_int = ^{irq_n, nmi_n, i_flag};
   assign inj_nmi    = 1'b0;
   assign inj_irq    = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      int_src_d = int_src_q;
      bus_addr  = pc_q;
      bus_rd_en = 1'b0;
      bus_sync  = 1'b0;

      case (state_q)
         RST_LO: begin
            bus_addr  = VEC_RST;
            bus_rd_en = 1'b1;
            state_d   = RST_HI;
         end
         RST_HI: begin
            bus_addr   = VEC_RST_HI;
            bus_rd_en  = 1'b1;
            pc_d[7:0]  = bus.data_i;
            state_d    = RST_VEC;
         end
         RST_VEC: begin
            pc_d[15:8] = bus.data_i;
            state_d    = FETCH;
         end
         FETCH: begin
            bus_rd_en = 1'b1;
            bus_sync  = 1'b1;
            state_d   = LATCH;
         end
         LATCH: begin
            // Injected BRK leaves pc on the interrupted opcode.
            if (inj_nmi) begin
               opcode_d  = OP_BRK;
               int_src_d = INT_NMI;
            end else if (inj_irq) begin
               opcode_d  = OP_BRK;
               int_src_d = INT_IRQ;
            end else begin
               opcode_d  = bus.data_i;
               pc_d      = pc_q + 16'd1;
               int_src_d = INT_NONE;
            end
            state_d = EXEC;
         end
         EXEC: begin
            if (pc_load) begin
               pc_d = pc_in;
            end else if (pc_inc) begin
               pc_d = pc_q + 16'd1;
            end
            if (insn_done) begin
               state_d = FETCH;
            end
         end
         default: state_d = RST_LO;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= RST_LO;
         pc_q      <= 16'h0000;
         opcode_q  <= 8'h00;
         int_src_q <= INT_NONE;
      end else if (bus.rdy) begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         int_src_q <= int_src_d;
      end
   end

   // Bus outputs decode from held state, so they hold while rdy is low.
   assign bus.addr  = bus_addr;
   assign bus.rd_en = bus_rd_en;
   assign bus.sync  = bus_sync;
   assign ir_valid  = (state_q == LATCH) && bus.rdy;
   assign opcode    = opcode_q;
   assign pc        = pc_q;
   assign int_src   = int_src_q;
endmodule

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch: directed reset/boot sequence,
// a table of EXEC pc-update vectors, stall and reset corner cases, interrupt
// injection (expectations follow IFETCH_IRQ_EN), then random stimulus against
// a cycle-count reference model.
// -----------------------------------------------------------------------------
module tb_ifetch;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  opcode;
   logic        ir_valid;
   logic [15:0] pc;
   logic        pc_inc, pc_load, insn_done;
   logic [15:0] pc_in;
   logic        irq_n, nmi_n, i_flag;
   logic [1:0]  int_src;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:65535];

   always #5 i_clk = ~i_clk;

   ifetch_if bus ();

   ifetch dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .bus       (bus),
      .opcode    (opcode),
      .ir_valid  (ir_valid),
      .pc        (pc),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .pc_in     (pc_in),
      .insn_done (insn_done),
      .irq_n     (irq_n),
      .nmi_n     (nmi_n),
      .i_flag    (i_flag),
      .int_src   (int_src)
   );

   // Memory: data for the address presented in a ready read cycle appears next cycle.
   always @(posedge i_clk) begin
      if (bus.rd_en && bus.rdy) bus.data_i <= mem[bus.addr];
   end

   typedef struct {
      logic [15:0] base;
      logic        inc;
      logic        load;
      logic [15:0] pin;
      logic [15:0] exp;
   } vec_t;

   vec_t vt [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic quiet();
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      insn_done = 1'b0;
   endtask

   // Entered with DUT in EXEC; leaves it in EXEC with the new opcode.
   task automatic run_vec(input vec_t v);
      logic [15:0] nx;
      nx = v.exp + 16'd1;
      @(negedge i_clk); quiet(); pc_load = 1'b1; pc_in = v.base;
      @(negedge i_clk); pc_inc = v.inc; pc_load = v.load; pc_in = v.pin; insn_done = 1'b1;
      @(negedge i_clk); quiet(); #1;
      check("vec_fetch_addr", bus.addr, v.exp);
      check("vec_fetch_sync", bus.sync, 1);
      @(negedge i_clk); #1;
      check("vec_ir_valid", ir_valid, 1);
      @(negedge i_clk); #1;
      check("vec_opcode", opcode, mem[v.exp]);
      check("vec_pc_after", pc, nx);
   endtask

   task automatic irq_insn(input logic [7:0] exp_op, input logic [1:0] exp_src,
                           input logic [15:0] exp_pc, input string tag);
      @(negedge i_clk); quiet(); insn_done = 1'b1; pc_load = 1'b1; pc_in = 16'h5000;
      @(negedge i_clk); quiet();
      @(negedge i_clk); #1;
      check({tag, "_valid"}, ir_valid, 1);
      @(negedge i_clk); #1;
      check({tag, "_opcode"}, opcode, exp_op);
      check({tag, "_int_src"}, int_src, exp_src);
      check({tag, "_pc"}, pc, exp_pc);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  prev_op;
      logic [15:0] m_pc;
      logic [7:0]  m_op;
      int          m_wait;
      int          first_valid;
      logic        exp_valid;

      vt[0] = '{16'h1000, 1'b1, 1'b0, 16'h0000, 16'h1001};
      vt[1] = '{16'h1000, 1'b0, 1'b1, 16'h8000, 16'h8000};
      vt[2] = '{16'h1000, 1'b1, 1'b1, 16'h8000, 16'h8000};
      vt[3] = '{16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000};
      vt[4] = '{16'h2345, 1'b0, 1'b0, 16'h0000, 16'h2345};
      vt[5] = '{16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'hFFFF};

      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      mem[16'hFFFC] = 8'h34;
      mem[16'hFFFD] = 8'h12;
      mem[16'h1234] = 8'hA9;
      mem[16'h5000] = 8'hEA;

      i_rst = 1'b1; bus.rdy = 1'b1; quiet(); pc_in = 16'h0000;
      irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b0;

      // ---- reset state and boot through the reset vector
      @(negedge i_clk);
      @(negedge i_clk); #1;
      check("rst_addr", bus.addr, 16'hFFFC);
      check("rst_rd_en", bus.rd_en, 1);
      check("rst_pc", pc, 16'h0000);
      check("rst_opcode", opcode, 8'h00);
      check("rst_ir_valid", ir_valid, 0);
      check("rst_int_src", int_src, 0);
      @(negedge i_clk); i_rst = 1'b0; #1;
      check("rstlo_addr", bus.addr, 16'hFFFC);
      @(negedge i_clk); #1;
      check("rsthi_addr", bus.addr, 16'hFFFD);
      check("rsthi_rd_en", bus.rd_en, 1);
      @(negedge i_clk); #1;
      check("rstvec_rd_en", bus.rd_en, 0);
      check("rstvec_ir_valid", ir_valid, 0);
      @(negedge i_clk); #1;
      check("boot_pc", pc, 16'h1234);
      check("boot_fetch_addr", bus.addr, 16'h1234);
      check("boot_sync", bus.sync, 1);
      @(negedge i_clk); #1;
      check("boot_ir_valid", ir_valid, 1);
      check("boot_latch_sync", bus.sync, 0);
      @(negedge i_clk); #1;
      check("boot_opcode", opcode, 8'hA9);
      check("boot_pc_inc", pc, 16'h1235);
      check("boot_exec_valid", ir_valid, 0);

      // ---- operand consume, then insn_done; executor inputs ignored in FETCH
      pc_inc = 1'b1;
      @(negedge i_clk); quiet(); insn_done = 1'b1; #1;
      check("inc_pc", pc, 16'h1236);
      @(negedge i_clk); quiet();
      pc_inc = 1'b1; pc_load = 1'b1; pc_in = 16'hDEAD; insn_done = 1'b1; #1;
      check("done_fetch_addr", bus.addr, 16'h1236);
      check("done_fetch_sync", bus.sync, 1);
      @(negedge i_clk); quiet(); #1;
      check("latch_pc_hold", pc, 16'h1236);
      check("latch_ir_valid", ir_valid, 1);
      @(negedge i_clk); #1;
      check("exec_opcode", opcode, mem[16'h1236]);
      check("exec_pc", pc, 16'h1237);
      @(negedge i_clk); #1;
      check("exec_stays", bus.sync, 0);
      check("exec_no_valid", ir_valid, 0);

      // ---- table of EXEC pc-update vectors
      for (int i = 0; i < 6; i++) run_vec(vt[i]);

      // ---- rdy low for three cycles during LATCH
      prev_op = opcode;
      @(negedge i_clk); quiet(); insn_done = 1'b1; pc_load = 1'b1; pc_in = 16'h4000;
      @(negedge i_clk); quiet();
      @(negedge i_clk); bus.rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge i_clk);
         #1;
         check("stall_no_valid", ir_valid, 0);
         check("stall_opcode", opcode, prev_op);
         check("stall_pc", pc, 16'h4000);
      end
      @(negedge i_clk); bus.rdy = 1'b1; #1;
      check("stall_release_valid", ir_valid, 1);
      @(negedge i_clk); #1;
      check("stall_after_valid", ir_valid, 0);
      check("stall_opcode_new", opcode, mem[16'h4000]);
      check("stall_pc_new", pc, 16'h4001);

      // ---- interrupt injection
      @(negedge i_clk); quiet(); nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0;
      @(negedge i_clk);
`ifdef IFETCH_IRQ_EN
      irq_insn(8'h00, 2'b10, 16'h5000, "nmi");
      irq_insn(8'h00, 2'b01, 16'h5000, "irq");
`else
      irq_insn(8'hEA, 2'b00, 16'h5001, "nmi_off");
      irq_insn(8'hEA, 2'b00, 16'h5001, "irq_off");
`endif
      i_flag = 1'b1;
      irq_insn(8'hEA, 2'b00, 16'h5001, "masked");
      nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0;

      // ---- reset during EXEC
      @(negedge i_clk); quiet(); i_rst = 1'b1;
      @(negedge i_clk); #1;
      check("mid_rst_addr", bus.addr, 16'hFFFC);
      check("mid_rst_rd_en", bus.rd_en, 1);
      check("mid_rst_valid", ir_valid, 0);
      i_rst = 1'b0;
      first_valid = 0;
      for (int k = 1; k <= 10 && first_valid == 0; k++) begin
         if (k > 1) @(negedge i_clk);
         #1;
         if (ir_valid) first_valid = k;
      end
      check("mid_rst_latency", first_valid, 5);
      @(negedge i_clk); #1;
      check("mid_rst_opcode", opcode, 8'hA9);
      check("mid_rst_pc", pc, 16'h1235);

      // ---- random stimulus against a cycle-count model
      m_pc   = 16'h1235;
      m_op   = 8'hA9;
      m_wait = -1;   // -1: executing; otherwise ready cycles left before the latch cycle
      for (int c = 0; c < 3000; c++) begin
         @(negedge i_clk);
         bus.rdy   = ($urandom_range(0, 3) != 0);
         pc_inc    = $urandom_range(0, 1);
         pc_load   = ($urandom_range(0, 7) == 0);
         pc_in     = 16'($urandom);
         insn_done = ($urandom_range(0, 3) == 0);
         i_flag    = $urandom_range(0, 1);
         #1;
         exp_valid = (m_wait == 0) && bus.rdy;
         check("rnd_ir_valid", ir_valid, exp_valid);
         check("rnd_pc", pc, m_pc);
         if (m_wait == -1) check("rnd_opcode", opcode, m_op);
         if (m_wait == 1) begin
            check("rnd_sync", bus.sync, 1);
            check("rnd_fetch_addr", bus.addr, m_pc);
         end
         if (bus.rdy) begin
            if (m_wait == -1) begin
               if (pc_load) m_pc = pc_in;
               else if (pc_inc) m_pc = m_pc + 16'd1;
               if (insn_done) m_wait = 1;
            end else if (m_wait == 1) begin
               m_wait = 0;
            end else begin
               m_op   = mem[m_pc];
               m_pc   = m_pc + 16'd1;
               m_wait = -1;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
